// File: rtl/int_reg_file_sb.sv
// int_reg_file_sb: integer register file with write-through bypass and a busy-bit scoreboard
module int_reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 32,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output logic                  rs1_ready_o,
  output logic                  rs2_ready_o,
  input  logic                  issue_valid_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_addr_i,
  input  logic                  wb_valid_i,
  input  logic [ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_rd_data_i,
  output logic [NUM_REGS-1:0]   busy_o
);
  localparam logic [NUM_REGS-1:0] ONE = 1;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy, busy_nxt, wb_mask, issue_mask;
  logic wb_en, hit1, hit2;
  // reads see zeros while reset is held, even if a writeback is presented
  assign wb_en = arst_ni && wb_valid_i;
  assign hit1 = wb_en && wb_rd_addr_i == rs1_addr_i && rs1_addr_i != '0;
  assign hit2 = wb_en && wb_rd_addr_i == rs2_addr_i && rs2_addr_i != '0;
  assign rs1_data_o = rs1_addr_i == '0 ? '0 : hit1 ? wb_rd_data_i : regs[rs1_addr_i];
  assign rs2_data_o = rs2_addr_i == '0 ? '0 : hit2 ? wb_rd_data_i : regs[rs2_addr_i];
  assign rs1_ready_o = rs1_addr_i == '0 || !busy[rs1_addr_i] || hit1;
  assign rs2_ready_o = rs2_addr_i == '0 || !busy[rs2_addr_i] || hit2;
  assign busy_o = busy;
  // issue is applied after the writeback clear so the newer instruction keeps ownership
  always_comb begin
    wb_mask = wb_valid_i ? ONE << wb_rd_addr_i : '0;
    issue_mask = issue_valid_i ? ONE << issue_rd_addr_i : '0;
    busy_nxt = ((busy & ~wb_mask) | issue_mask) & ~ONE;
  end
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      busy <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      busy <= busy_nxt;
      if (wb_valid_i && wb_rd_addr_i != '0) regs[wb_rd_addr_i] <= wb_rd_data_i;
    end
endmodule

// File: tb/tb_int_reg_file_sb.sv
// tb_int_reg_file_sb: directed checks of int_reg_file_sb plus a short randomised run against a reference model
module tb_int_reg_file_sb;
  logic clk_i = 0, arst_ni = 0;
  logic [4:0] rs1_addr_i = 0, rs2_addr_i = 0, issue_rd_addr_i = 0, wb_rd_addr_i = 0;
  logic [31:0] rs1_data_o, rs2_data_o, wb_rd_data_i = 0, busy_o;
  logic rs1_ready_o, rs2_ready_o, issue_valid_i = 0, wb_valid_i = 0;
  int nvec = 0, nerr = 0;
  logic [31:0] regs_m [32];
  logic [31:0] busy_m;

  int_reg_file_sb dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_ready_o(rs1_ready_o), .rs2_ready_o(rs2_ready_o),
    .issue_valid_i(issue_valid_i), .issue_rd_addr_i(issue_rd_addr_i),
    .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid_i = v; wb_rd_addr_i = a; wb_rd_data_i = d;
  endtask

  task automatic iss(input logic v, input logic [4:0] a);
    issue_valid_i = v; issue_rd_addr_i = a;
  endtask

  function automatic logic [31:0] m_data(input logic [4:0] a);
    if (a == 0) return 0;
    if (wb_valid_i && wb_rd_addr_i == a) return wb_rd_data_i;
    return regs_m[a];
  endfunction

  function automatic logic m_ready(input logic [4:0] a);
    return a == 0 || !busy_m[a] || (wb_valid_i && wb_rd_addr_i == a);
  endfunction

  initial begin
    #12 arst_ni = 1;
    // preload state, then reset it away
    wb(1, 5, 32'h111); iss(1, 7); tick();
    wb(1, 9, 32'h222); iss(0, 0); tick();
    arst_ni = 0; wb(1, 5, 32'h999); rs1_addr_i = 5; rs2_addr_i = 9; #1;
    check("rst_rs1_data", rs1_data_o, 0);
    check("rst_rs1_ready", 32'(rs1_ready_o), 1);
    check("rst_rs2_data", rs2_data_o, 0);
    check("rst_busy", busy_o, 0);
    wb(0, 0, 0); #1 arst_ni = 1; rs1_addr_i = 7; #1;
    check("post_rst_rs2_data", rs2_data_o, 0);
    check("post_rst_ready7", 32'(rs1_ready_o), 1);
    // write-through bypass then stored value
    wb(1, 5, 32'hDEADBEEF); rs1_addr_i = 5; #1;
    check("bypass_rs1", rs1_data_o, 32'hDEADBEEF);
    tick(); wb(0, 0, 0); #1;
    check("stored_rs1", rs1_data_o, 32'hDEADBEEF);
    // x0 stays zero
    wb(1, 0, 32'hFFFFFFFF); rs1_addr_i = 0; #1;
    check("x0_bypass", rs1_data_o, 0);
    check("x0_ready", 32'(rs1_ready_o), 1);
    tick(); wb(0, 0, 0); #1;
    check("x0_stored", rs1_data_o, 0);
    // busy set by issue, cleared by writeback
    iss(1, 7); tick(); iss(0, 0); rs2_addr_i = 7; #1;
    check("busy7", busy_o, 32'h80);
    check("ready7_busy", 32'(rs2_ready_o), 0);
    wb(1, 7, 32'h12345678); #1;
    check("ready7_wb", 32'(rs2_ready_o), 1);
    check("data7_wb", rs2_data_o, 32'h12345678);
    tick(); wb(0, 0, 0); #1;
    check("busy7_clr", busy_o, 0);
    check("data7_stored", rs2_data_o, 32'h12345678);
    // issue beats a same-cycle writeback
    iss(1, 3); wb(1, 3, 32'hA5A5A5A5); tick(); iss(0, 0); wb(0, 0, 0);
    rs1_addr_i = 3; rs2_addr_i = 3; #1;
    check("reg3", rs1_data_o, 32'hA5A5A5A5);
    check("reg3_port2", rs2_data_o, 32'hA5A5A5A5);
    check("busy3", busy_o, 32'h8);
    check("ready3", 32'(rs1_ready_o), 0);
    // issue to x0 sets nothing; WAW keeps the bit; writeback to non-busy reg
    iss(1, 0); tick();
    iss(1, 3); tick(); iss(0, 0); #1;
    check("busy_waw", busy_o, 32'h8);
    wb(1, 3, 32'h1); tick(); wb(1, 4, 32'h44); tick(); wb(0, 0, 0); rs1_addr_i = 4; #1;
    check("busy_clear_all", busy_o, 0);
    check("reg4", rs1_data_o, 32'h44);
    // asynchronous reset between edges
    iss(1, 10); tick(); iss(0, 0); #1;
    check("busy10", busy_o, 32'h400);
    arst_ni = 0; #1;
    check("async_busy", busy_o, 0);
    check("async_reg4", rs1_data_o, 0);
    #1 arst_ni = 1;
    // randomised phase against the model
    for (int i = 0; i < 32; i++) regs_m[i] = 0;
    busy_m = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        wb(0, 0, 0); iss(0, 0); arst_ni = 0; #1;
        check("rand_rst_busy", busy_o, 0);
        for (int i = 0; i < 32; i++) regs_m[i] = 0;
        busy_m = 0;
        #1 arst_ni = 1;
      end
      rs1_addr_i = 5'($urandom_range(0, 7)); rs2_addr_i = 5'($urandom_range(0, 7));
      iss(1'($urandom), 5'($urandom_range(0, 7)));
      wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      #1;
      check("rand_rs1_data", rs1_data_o, m_data(rs1_addr_i));
      check("rand_rs2_data", rs2_data_o, m_data(rs2_addr_i));
      check("rand_rs1_ready", 32'(rs1_ready_o), 32'(m_ready(rs1_addr_i)));
      check("rand_rs2_ready", 32'(rs2_ready_o), 32'(m_ready(rs2_addr_i)));
      check("rand_busy", busy_o, busy_m);
      if (wb_valid_i && wb_rd_addr_i != 0) begin
        regs_m[wb_rd_addr_i] = wb_rd_data_i;
        busy_m[wb_rd_addr_i] = 0;
      end
      if (issue_valid_i && issue_rd_addr_i != 0) busy_m[issue_rd_addr_i] = 1;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
